frog_light: RTL and testbench

- Single-cell state element of the 16x16 frog-position LED grid.
- Each cell stores whether the frog currently occupies that pixel.
- Cells are tiled by the parent grid, which wires each cell's neighbour inputs to adjacent cells' lightOn outputs.
- One cell per grid is built as the start cell (START_CELL=1), replacing the separate start-frog element, so the frog appears there after reset.

---
 rtl/frog_light_if.sv | 33 +++
 rtl/frog_light.sv | 67 ++++++
 tb/tb_frog_light.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/frog_light_if.sv
`default_nettype none
// ============================================================================
// Module      : frog_light_if
// Description : Signal bundle for one frog-grid cell. Carries the move
//               requests, the game-over flag, the four neighbour lightOn
//               inputs and this cell's own lightOn output.
//               master : grid/controller side (drives requests and neighbours)
//               slave  : cell side (consumes requests, drives lightOn)
// Revision    : 1.0 - initial release
// ============================================================================
interface frog_light_if;
    logic lost;     // game over: clears the frog
    logic L;        // move-left pulse
    logic R;        // move-right pulse
    logic U;        // move-up pulse
    logic D;        // move-down pulse
    logic NL;       // left neighbour lightOn (next higher column)
    logic NR;       // right neighbour lightOn (next lower column)
    logic NU;       // upper neighbour lightOn (next lower row)
    logic ND;       // lower neighbour lightOn (next higher row)
    logic lightOn;  // this cell's registered occupancy

    modport master (
        output lost, L, R, U, D, NL, NR, NU, ND,
        input  lightOn
    );

    modport slave (
        input  lost, L, R, U, D, NL, NR, NU, ND,
        output lightOn
    );
endinterface
`default_nettype wire

// File: rtl/frog_light.sv
`default_nettype none
// ============================================================================
// Module      : frog_light
// Description : One cell of the 16x16 frog-position LED grid. A single flop
//               records whether the frog sits on this pixel. The frog enters
//               when exactly one move request is active and the neighbour on
//               the opposite side of the move is lit; it leaves on any valid
//               move that does not bring it in. lost clears the cell.
//               With START_CELL=1 the cell comes out of reset lit.
// Ports       : Clock   - system clock, rising edge
//               reset   - asynchronous, active-high reset
//               bus     - frog_light_if.slave (lost, L/R/U/D requests,
//                         NL/NR/NU/ND neighbours, lightOn output)
// Revision    : 1.0 - initial release
// ============================================================================
module frog_light #(
    parameter bit START_CELL = 1'b0
) (
    input  wire logic    Clock,
    input  wire logic    reset,
    frog_light_if.slave  bus
);

    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_ON  = 1'b1;
    localparam logic [0:0] c_RST_STATE = START_CELL ? ST_ON : ST_OFF;

    logic [0:0] state_q;
    logic [0:0] state_d;

    logic [3:0] w_reqs;
    logic       w_move;
    logic       w_enter;

    assign w_reqs = {bus.L, bus.R, bus.U, bus.D};

    // Exactly one request: non-zero and clearing the lowest set bit leaves
    // nothing. Simultaneous presses are ignored so the frog never splits.
    assign w_move = (w_reqs != 4'd0) && ((w_reqs & (w_reqs - 4'd1)) == 4'd0);

    // The frog arrives from the side opposite to the direction of travel.
    assign w_enter = (bus.L & bus.NR) | (bus.R & bus.NL) |
                     (bus.U & bus.ND) | (bus.D & bus.NU);

    always_comb begin
        state_d = state_q;
        if (bus.lost) begin
            state_d = ST_OFF;
        end else if (w_move) begin
            // A valid move either brings the frog in or takes it away;
            // moving off the grid edge therefore just extinguishes it.
            state_d = w_enter ? ST_ON : ST_OFF;
        end
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= c_RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.lightOn = (state_q == ST_ON);

endmodule
`default_nettype wire

// File: tb/tb_frog_light.sv
`default_nettype none
// ============================================================================
// Module      : tb_frog_light
// Description : Self-checking bench for frog_light. Drives a plain cell
//               (START_CELL=0) and a start cell (START_CELL=1) with identical
//               stimulus; a reference model pushes expected lightOn values to
//               a scoreboard queue which is drained after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frog_light;

    typedef struct {
        string tag;
        int    which;   // 0 = plain cell, 1 = start cell
        logic  exp;
    } exp_t;

    logic Clock;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];
    logic m_state [2];  // reference model state per DUT

    frog_light_if bus0 ();
    frog_light_if bus1 ();

    frog_light #(.START_CELL(1'b0)) u_cell (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    frog_light #(.START_CELL(1'b1)) u_start (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent model of the cell's next-state rule.
    function automatic logic model_next(
        input logic cur, input logic lost,
        input logic l, input logic r, input logic u, input logic d,
        input logic nl, input logic nr, input logic nu, input logic nd
    );
        int n;
        n = int'(l) + int'(r) + int'(u) + int'(d);
        if (lost) return 1'b0;
        if (n != 1) return cur;
        if (l) return nr;
        if (r) return nl;
        if (u) return nd;
        return nu;
    endfunction

    function automatic logic dut_out(input int which);
        return (which == 0) ? bus0.lightOn : bus1.lightOn;
    endfunction

    task automatic push_both(input string tag);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.tag   = $sformatf("%s/c%0d", tag, k);
            e.which = k;
            e.exp   = m_state[k];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, dut_out(e.which), e.exp);
        end
    endtask

    // Drive one cycle of stimulus onto both cells, predict, clock, compare.
    task automatic step(
        input string tag, input logic lost,
        input logic l, input logic r, input logic u, input logic d,
        input logic nl, input logic nr, input logic nu, input logic nd
    );
        bus0.lost = lost; bus1.lost = lost;
        bus0.L = l;  bus1.L = l;
        bus0.R = r;  bus1.R = r;
        bus0.U = u;  bus1.U = u;
        bus0.D = d;  bus1.D = d;
        bus0.NL = nl; bus1.NL = nl;
        bus0.NR = nr; bus1.NR = nr;
        bus0.NU = nu; bus1.NU = nu;
        bus0.ND = nd; bus1.ND = nd;
        for (int k = 0; k < 2; k++) begin
            if (reset) m_state[k] = (k == 1);
            else m_state[k] = model_next(m_state[k], lost, l, r, u, d, nl, nr, nu, nd);
        end
        push_both(tag);
        @(posedge Clock);
        #1;
        drain();
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus0.lost = 1'b0; bus1.lost = 1'b0;
        bus0.L = 1'b0; bus0.R = 1'b0; bus0.U = 1'b0; bus0.D = 1'b0;
        bus1.L = 1'b0; bus1.R = 1'b0; bus1.U = 1'b0; bus1.D = 1'b0;
        bus0.NL = 1'b0; bus0.NR = 1'b0; bus0.NU = 1'b0; bus0.ND = 1'b0;
        bus1.NL = 1'b0; bus1.NR = 1'b0; bus1.NU = 1'b0; bus1.ND = 1'b0;

        // Asynchronous reset before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        m_state[0] = 1'b0;
        m_state[1] = 1'b1;
        push_both("async_rst");
        drain();
        for (int i = 0; i < 5; i++) idle($sformatf("rst_hold%0d", i));
        reset = 1'b0;
        for (int i = 0; i < 2; i++) idle($sformatf("post_rst%0d", i));

        // Up off the start position with nobody below: start cell goes dark.
        step("up_leave", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Up with the lower neighbour lit: frog enters.
        step("up_enter", 0, 0, 0, 1, 0, 0, 0, 0, 1);

        // Entry per direction on dark cells.
        step("clr_a",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("l_enter",  0, 1, 0, 0, 0, 0, 1, 0, 0);
        step("clr_b",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("r_enter",  0, 0, 1, 0, 0, 1, 0, 0, 0);
        step("clr_c",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("d_enter",  0, 0, 0, 0, 1, 0, 0, 1, 0);
        step("clr_d",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("l_wrong",  0, 1, 0, 0, 0, 1, 0, 0, 0);

        // Simultaneous requests are ignored.
        step("set_on",   0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("lu_hold",  0, 1, 0, 1, 0, 0, 0, 0, 0);
        step("clr_e",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("ud_hold",  0, 0, 0, 1, 1, 0, 0, 0, 1);

        // Holding a request moves the frog each cycle: in, then out, then in.
        step("hold_in",  0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("hold_out", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("hold_in2", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Off the grid edge: frog vanishes.
        step("edge_off", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // lost dominates a valid entry and holds the cell dark.
        step("set_on2",  0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("lost0",    1, 0, 0, 1, 0, 0, 0, 0, 1);
        step("lost1",    1, 0, 0, 1, 0, 0, 0, 0, 1);
        step("lost2",    1, 0, 1, 0, 0, 1, 0, 0, 0);
        step("after_lost", 0, 0, 1, 0, 0, 1, 0, 0, 0);

        // Reset in mid-cycle while both cells are lit and a move is pending.
        bus0.U = 1'b1; bus1.U = 1'b1;
        bus0.R = 1'b0; bus1.R = 1'b0;
        bus0.NL = 1'b0; bus1.NL = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_state[0] = 1'b0;
        m_state[1] = 1'b1;
        push_both("mid_rst");
        drain();
        step("mid_rst_edge", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        // First edge after reset evaluates normally.
        step("post_mid", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("post_mid2", 0, 0, 0, 0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
